// File: rtl/serial_cfg_receiver.sv
// Chip-side receiver for the FPGA configuration link: oversamples sclk/sdin on
// the main clock, deserializes address+data frames and commits them to a register file.
module serial_cfg_receiver #(
  parameter int ADDR_BITS = 2,
  parameter int DATA_BITS = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                                  i_mainclk,
  input  logic                                  i_reset,
  input  logic                                  i_sclk,
  input  logic                                  i_sdin,
  output logic                                  o_ready,
  output logic                                  o_wr_pulse,
  output logic                                  o_frame_err,
  output logic [DATA_BITS-1:0]                  o_gainA1,
  output logic [(2**ADDR_BITS)*DATA_BITS-1:0]   o_cfg_bus
);

  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int NUM_REGS   = 2**ADDR_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int TMR_W      = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic                  r_sclk_s1;
  logic                  r_sclk_s2;
  logic                  r_sclk_prev;
  logic                  r_sdin_s1;
  logic                  r_sdin_s2;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [TMR_W-1:0]      r_timer;
  logic [1:0]            r_state;
  logic                  r_ready;
  logic                  r_wr_pulse;
  logic                  r_frame_err;
  logic [DATA_BITS-1:0]  r_regs [NUM_REGS];

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_edge;
  logic                  w_commit;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [DATA_BITS-1:0]  w_data;

  assign w_rise   = ~r_sclk_prev & r_sclk_s2;
  assign w_fall   = r_sclk_prev & ~r_sclk_s2;
  assign w_edge   = w_rise | w_fall;
  assign w_addr   = r_shift[FRAME_BITS-1 -: ADDR_BITS];
  assign w_data   = r_shift[DATA_BITS-1:0];
  assign w_commit = (r_state == S_CHECK) && (r_cnt == CNT_FULL);

  // sclk and sdin share the same synchronizer depth so sampled data lines up with the edge.
  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      r_sclk_s1   <= 1'b1;
      r_sclk_s2   <= 1'b1;
      r_sclk_prev <= 1'b1;
      r_sdin_s1   <= 1'b0;
      r_sdin_s2   <= 1'b0;
    end else begin
      r_sclk_s1   <= i_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_sdin_s1   <= i_sdin;
      r_sdin_s2   <= r_sdin_s1;
    end
  end

  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_pulse <= 1'b0;
      // Shared by IDLE and SHIFT so the very first rising edge of a frame is not lost.
      if ((r_state == S_IDLE || r_state == S_SHIFT) && w_rise) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], r_sdin_s2};
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_edge) begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_edge) begin
            r_timer <= '0;
          end else if (r_timer == TMR_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_CHECK: begin
          if (r_cnt == CNT_FULL) begin
            r_ready    <= 1'b1;
            r_wr_pulse <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_cnt   <= '0;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge i_mainclk) begin
        if (i_reset) begin
          r_regs[gi] <= '0;
        end else if (w_commit && (w_addr == ADDR_BITS'(gi))) begin
          r_regs[gi] <= w_data;
        end
      end
      assign o_cfg_bus[gi*DATA_BITS +: DATA_BITS] = r_regs[gi];
    end
  endgenerate

  assign o_gainA1    = r_regs[0];
  assign o_ready     = r_ready;
  assign o_wr_pulse  = r_wr_pulse;
  assign o_frame_err = r_frame_err;

endmodule
